// File: rtl/fft_inplc_frame_ctrl_if.sv
// Bundles the ADC stream, the FFT core buffer/readout handshake and the per-bin power output.
// The controller uses the master view; the environment (core model, ADC source, sink) uses the slave view.
interface fft_inplc_frame_ctrl_if #(
    parameter int WIDTH  = 18,
    parameter int POINTS = 256
);
    localparam int IW = $clog2(POINTS);

    logic                     s_valid;
    logic                     s_ready;
    logic signed [WIDTH-1:0]  s_re;
    logic signed [WIDTH-1:0]  s_im;

    logic signed [WIDTH-1:0]  fft_datai_re;
    logic signed [WIDTH-1:0]  fft_datai_im;
    logic                     fft_datai_valid;
    logic                     fft_buf_ready;
    logic                     fft_outp_ready;
    logic                     fft_read_outp;
    logic signed [WIDTH-1:0]  fft_datao_re;
    logic signed [WIDTH-1:0]  fft_datao_im;
    logic                     fft_datao_valid;

    logic [2*WIDTH-1:0]       m_power;
    logic [IW-1:0]            m_index;
    logic                     m_valid;
    logic                     m_last;
    logic                     err;

    modport master (
        input  s_valid, s_re, s_im,
        input  fft_buf_ready, fft_outp_ready,
        input  fft_datao_re, fft_datao_im, fft_datao_valid,
        output s_ready,
        output fft_datai_re, fft_datai_im, fft_datai_valid, fft_read_outp,
        output m_power, m_index, m_valid, m_last, err
    );

    modport slave (
        output s_valid, s_re, s_im,
        output fft_buf_ready, fft_outp_ready,
        output fft_datao_re, fft_datao_im, fft_datao_valid,
        input  s_ready,
        input  fft_datai_re, fft_datai_im, fft_datai_valid, fft_read_outp,
        input  m_power, m_index, m_valid, m_last, err
    );
endinterface

// File: rtl/fft_inplc_frame_ctrl.sv
// Frame controller for the in-place FFT core: loads POINTS samples per frame, requests the
// readout, and turns each returned bin into an unsigned re^2+im^2 power with its bin index.
module fft_inplc_frame_ctrl #(
    parameter int POINTS  = 256,
    parameter int WIDTH   = 18,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fft_inplc_frame_ctrl_if.master bus
);
    localparam int IW = $clog2(POINTS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_OUT = 2'd2,
        READ     = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            read_outp_q, read_outp_d;

    logic            s_xfer;
    logic            beat;
    logic            last_beat;
    logic            timed_out;

    logic signed [WIDTH-1:0] datai_re_q, datai_im_q;
    logic                    datai_valid_q;

    logic signed [WIDTH-1:0] comp [2];
    logic [PW-2:0]           sq_d [2];
    logic [PW-2:0]           sq_q [2];
    logic                    p1_valid_q, p1_last_q;
    logic [IW-1:0]           p1_idx_q;

    logic [PW-1:0]           m_power_q;
    logic [IW-1:0]           m_index_q;
    logic                    m_valid_q, m_last_q;

    assign s_xfer    = (state_q == LOAD) && bus.s_valid;
    assign beat      = (state_q == READ) && bus.fft_datao_valid;
    assign last_beat = beat && (cnt_q == IW'(POINTS - 1));
    assign timed_out = (state_q == READ) && !bus.fft_datao_valid && (timer_q == TW'(TIMEOUT - 1));

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            read_outp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            read_outp_q <= read_outp_d;
        end
    end

    // FSM next-state logic; one counter serves as sample count in LOAD and beat index in READ
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        err_d       = err_q;
        read_outp_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fft_buf_ready) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (s_xfer) begin
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_q == IW'(POINTS - 1)) begin
                        state_d = WAIT_OUT;
                    end
                end
            end
            WAIT_OUT: begin
                if (bus.fft_outp_ready) begin
                    state_d     = READ;
                    read_outp_d = 1'b1;
                    cnt_d       = '0;
                    timer_d     = '0;
                end
            end
            READ: begin
                if (beat) begin
                    cnt_d   = cnt_q + IW'(1);
                    timer_d = '0;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A result beat the controller did not ask for means the core and host are out of step.
        if (bus.fft_datao_valid && (state_q != READ)) begin
            err_d = 1'b1;
        end
    end

    // FSM outputs
    always_comb begin
        bus.s_ready         = (state_q == LOAD);
        bus.fft_read_outp   = read_outp_q;
        bus.err             = err_q;
        bus.fft_datai_re    = datai_re_q;
        bus.fft_datai_im    = datai_im_q;
        bus.fft_datai_valid = datai_valid_q;
        bus.m_power         = m_power_q;
        bus.m_index         = m_index_q;
        bus.m_valid         = m_valid_q;
        bus.m_last          = m_last_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            datai_re_q    <= '0;
            datai_im_q    <= '0;
            datai_valid_q <= 1'b0;
        end else begin
            datai_valid_q <= s_xfer;
            if (s_xfer) begin
                datai_re_q <= bus.s_re;
                datai_im_q <= bus.s_im;
            end
        end
    end

    assign comp[0] = bus.fft_datao_re;
    assign comp[1] = bus.fft_datao_im;

    // Stage 1: a square of a WIDTH-bit signed value never exceeds 2^(2W-2), so 2W-1 bits suffice.
    for (genvar gi = 0; gi < 2; gi++) begin : g_square
        logic signed [PW-1:0] ext;
        assign ext      = {{WIDTH{comp[gi][WIDTH-1]}}, comp[gi]};
        assign sq_d[gi] = (PW-1)'(ext * ext);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sq_q[gi] <= '0;
            end else if (beat) begin
                sq_q[gi] <= sq_d[gi];
            end
        end
    end

    // Pipe keeps running after a timeout so already-accepted beats still come out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_idx_q   <= '0;
            m_power_q  <= '0;
            m_index_q  <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            p1_valid_q <= beat;
            p1_last_q  <= last_beat;
            if (beat) begin
                p1_idx_q <= cnt_q;
            end
            m_valid_q <= p1_valid_q;
            m_last_q  <= p1_valid_q & p1_last_q;
            if (p1_valid_q) begin
                m_power_q <= {1'b0, sq_q[0]} + {1'b0, sq_q[1]};
                m_index_q <= p1_idx_q;
            end
        end
    end
endmodule

// File: tb/tb_fft_inplc_frame_ctrl.sv
// Directed bench for fft_inplc_frame_ctrl (POINTS=16, WIDTH=18, TIMEOUT=32): a frame-level
// model predicts every output each cycle, and literal checks pin the model's key numbers.
module tb_fft_inplc_frame_ctrl;
    localparam int P  = 16;
    localparam int W  = 18;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_inplc_frame_ctrl_if #(.WIDTH(W), .POINTS(P)) bus ();

    fft_inplc_frame_ctrl #(.POINTS(P), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        longint due;
        longint pw;
        int     idx;
        bit     last;
    } mout_t;

    mout_t  pq[$];
    int     ph = 0;          // 0 idle, 1 loading, 2 waiting for results, 3 reading
    int     left = 0;
    int     beats = 0;
    int     quiet = 0;
    longint cyc = 0;
    bit     e_dv = 0, e_rd = 0, e_err = 0;
    longint e_dre = 0, e_dim = 0;

    always @(posedge clk) begin
        int     ph_was;
        longint re, im;
        mout_t  m;
        e_dv   = 0;
        e_rd   = 0;
        ph_was = ph;
        if (rst) begin
            ph = 0; e_err = 0; e_dre = 0; e_dim = 0;
            pq.delete();
        end else begin
            case (ph)
                0: if (bus.fft_buf_ready) begin ph = 1; left = P; end
                1: if (bus.s_valid) begin
                       e_dv  = 1;
                       e_dre = bus.s_re;
                       e_dim = bus.s_im;
                       left--;
                       if (left == 0) ph = 2;
                   end
                2: if (bus.fft_outp_ready) begin ph = 3; e_rd = 1; beats = 0; quiet = 0; end
                default: begin
                    if (bus.fft_datao_valid) begin
                        re     = bus.fft_datao_re;
                        im     = bus.fft_datao_im;
                        m.due  = cyc + 2;
                        m.pw   = re * re + im * im;
                        m.idx  = beats;
                        m.last = (beats == P - 1);
                        pq.push_back(m);
                        beats++;
                        quiet = 0;
                        if (beats == P) ph = 0;
                    end else begin
                        quiet++;
                        if (quiet == TO) begin e_err = 1; ph = 0; end
                    end
                end
            endcase
            if (bus.fft_datao_valid && ph_was != 3) e_err = 1;
        end
        cyc++;
    end

    // ---------------- per-cycle compare + monitors ----------------
    int     n_dv = 0, n_rd = 0, n_mv = 0, n_ml = 0;
    longint last_dre = 0;
    longint pw_cap [P];

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("s_ready", bus.s_ready, longint'(ph == 1));
            check("datai_valid", bus.fft_datai_valid, e_dv);
            if (e_dv) begin
                check("datai_re", longint'(bus.fft_datai_re), e_dre);
                check("datai_im", longint'(bus.fft_datai_im), e_dim);
            end
            check("read_outp", bus.fft_read_outp, e_rd);
            check("err", bus.err, e_err);
            if (pq.size() > 0 && pq[0].due == cyc) begin
                check("m_valid", bus.m_valid, 1);
                check("m_power", longint'(bus.m_power), pq[0].pw);
                check("m_index", longint'(bus.m_index), pq[0].idx);
                check("m_last", bus.m_last, pq[0].last);
                void'(pq.pop_front());
            end else begin
                check("m_valid_idle", bus.m_valid, 0);
                check("m_last_idle", bus.m_last, 0);
            end
            if (bus.fft_datai_valid) begin n_dv++; last_dre = bus.fft_datai_re; end
            if (bus.fft_read_outp) n_rd++;
            if (bus.m_valid) begin n_mv++; pw_cap[bus.m_index] = longint'(bus.m_power); end
            if (bus.m_last) n_ml++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int base, input bit gappy);
        int n;
        bus.fft_buf_ready = 1'b1;
        tick();
        bus.fft_buf_ready = 1'b0;
        n = gappy ? 2 * P + 4 : P + 4;
        for (int k = 0; k < n; k++) begin
            bus.s_valid = gappy ? (k % 2 == 0) : 1'b1;
            bus.s_re    = W'(base + k);
            bus.s_im    = gappy ? W'(-k) : '0;
            tick();
        end
        bus.s_valid = 1'b0;
    endtask

    // mode 0: 3-4j; mode 1: alternating most-negative pair / (b-8)+3bj; mode 2: gapped b+(b+1)j
    task automatic read_frame(input int mode, input int nbeats);
        bus.fft_outp_ready = 1'b1;
        tick();
        bus.fft_outp_ready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (mode == 2) begin
                bus.fft_datao_valid = 1'b0;
                tick();
            end
            bus.fft_datao_valid = 1'b1;
            case (mode)
                0: begin bus.fft_datao_re = W'(3); bus.fft_datao_im = W'(-4); end
                1: begin
                    if (b % 2 == 0) begin
                        bus.fft_datao_re = W'(-(1 <<< (W - 1)));
                        bus.fft_datao_im = W'(-(1 <<< (W - 1)));
                    end else begin
                        bus.fft_datao_re = W'(b - 8);
                        bus.fft_datao_im = W'(3 * b);
                    end
                end
                default: begin bus.fft_datao_re = W'(b); bus.fft_datao_im = W'(b + 1); end
            endcase
            tick();
        end
        bus.fft_datao_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d_dv, d_rd, d_mv, d_ml, n;
        bus.s_valid = 0; bus.s_re = '0; bus.s_im = '0;
        bus.fft_buf_ready = 0; bus.fft_outp_ready = 0;
        bus.fft_datao_valid = 0; bus.fft_datao_re = '0; bus.fft_datao_im = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst s_ready", bus.s_ready, 0);
        check("rst datai_valid", bus.fft_datai_valid, 0);
        check("rst datai_re", longint'(bus.fft_datai_re), 0);
        check("rst read_outp", bus.fft_read_outp, 0);
        check("rst m_power", longint'(bus.m_power), 0);
        check("rst m_index", longint'(bus.m_index), 0);
        check("rst err", bus.err, 0);
        rst = 1'b0;
        tick();

        // continuous load of re=k
        d_dv = n_dv;
        load_frame(0, 1'b0);
        check("cont load pulses", n_dv - d_dv, 16);
        check("cont last sample", last_dre, 15);

        // readout of 3-4j
        d_rd = n_rd; d_mv = n_mv; d_ml = n_ml;
        read_frame(0, P);
        repeat (4) tick();
        check("read_outp pulses", n_rd - d_rd, 1);
        check("bins 3-4j", n_mv - d_mv, 16);
        check("last strobes", n_ml - d_ml, 1);
        check("power bin0", pw_cap[0], 25);
        check("power bin15", pw_cap[15], 25);

        // gapped load
        d_dv = n_dv;
        load_frame(100, 1'b1);
        check("gap load pulses", n_dv - d_dv, 16);
        check("gap last sample", last_dre, 130);

        // extreme values
        d_mv = n_mv;
        read_frame(1, P);
        repeat (4) tick();
        check("bins extreme", n_mv - d_mv, 16);
        check("power extreme", pw_cap[0], 64'h8_0000_0000);
        check("power bin1", pw_cap[1], 58);
        check("power bin15 mixed", pw_cap[15], 2074);

        // timeout after 5 beats
        load_frame(7, 1'b0);
        d_mv = n_mv; d_ml = n_ml;
        read_frame(0, 5);
        n = 0;
        while (!bus.err && n < 100) begin
            tick();
            n++;
        end
        check("timeout idle cycles", n, 32);
        check("timeout bins", n_mv - d_mv, 5);
        check("timeout no last", n_ml - d_ml, 0);
        repeat (10) tick();
        check("err sticky", bus.err, 1);

        // reset mid-load after 7 samples
        bus.fft_buf_ready = 1'b1;
        tick();
        bus.fft_buf_ready = 1'b0;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.s_re = W'(50 + k);
            tick();
        end
        bus.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid rst s_ready", bus.s_ready, 0);
        check("mid rst datai_valid", bus.fft_datai_valid, 0);
        check("mid rst err", bus.err, 0);
        rst = 1'b0;
        tick();
        d_dv = n_dv; d_ml = n_ml;
        load_frame(200, 1'b0);
        check("fresh load pulses", n_dv - d_dv, 16);
        check("fresh last sample", last_dre, 215);
        read_frame(2, P);
        repeat (4) tick();
        check("fresh last strobe", n_ml - d_ml, 1);
        check("power gapped bin5", pw_cap[5], 61);

        // stray result beat while idle
        d_mv = n_mv;
        bus.fft_datao_valid = 1'b1;
        tick();
        bus.fft_datao_valid = 1'b0;
        check("stray beat err", bus.err, 1);
        repeat (3) tick();
        check("stray beat no bin", n_mv - d_mv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_inplc_frame_ctrl.md
# fft_inplc_frame_ctrl

Host-side frame controller for the in-place FFT core: the initiator on the core's buffer/readout handshake. It gathers ADC samples from a valid/ready stream, loads exactly POINTS samples into the core when the core signals BUF_READY, and issues the READ_OUTP request once OUTP_READY is high. It then collects POINTS result beats and emits per-bin power (re²+im²) with bin index to downstream feature logic.

## Interface
- POINTS, 256, FFT length; power of two, 16..4096.
- WIDTH, 18, sample/result bit width per component (signed two's complement).
- TIMEOUT, 4096, max idle cycles between READ_OUTP and each result beat before abort.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; **synchronous, active-high**.
- S_VALID  in  1  ADC sample valid.
- S_READY  out  1  sample accept; a transfer occurs when S_VALID&S_READY.
- S_RE, S_IM  in  WIDTH each  sample real/imaginary parts.
- FFT_DATAI_RE, FFT_DATAI_IM  out  WIDTH each  to core DATAI_RE/IM.
- FFT_DATAI_VALID  out  1  to core DATAI_VALID.
- FFT_BUF_READY  in  1  from core BUF_READY.
- FFT_OUTP_READY  in  1  from core OUTP_READY.
- FFT_READ_OUTP  out  1  to core READ_OUTP; one-cycle pulse.
- FFT_DATAO_RE, FFT_DATAO_IM  in  WIDTH each  from core DATAO_RE/IM.
- FFT_DATAO_VALID  in  1  from core DATAO_VALID.
- M_POWER  out  2*WIDTH  unsigned re²+im².
- M_INDEX  out  log2(POINTS)  bin index.
- M_VALID  out  1  one-cycle strobe per bin; no backpressure.
- M_LAST  out  1  high with M_VALID on bin POINTS-1.
- ERR  out  1  sticky timeout/protocol error; cleared only by RST.

## Operation
- States: IDLE, LOAD, WAIT_OUT, READ.
- IDLE: S_READY=0. On FFT_BUF_READY=1 -> LOAD, load counter=0.
- LOAD: S_READY=1. Each transfer registers S_RE/S_IM onto FFT_DATAI_* and asserts FFT_DATAI_VALID for one cycle; counter++. On the POINTS-th transfer -> WAIT_OUT (S_READY low next cycle). Gaps in S_VALID are allowed; FFT_DATAI_VALID simply stays low.
- FFT_BUF_READY dropping during LOAD: not an error; loading continues (core latches frame start).
- WAIT_OUT: S_READY=0. On FFT_OUTP_READY=1: FFT_READ_OUTP=1 for exactly one cycle, beat counter=0, timer=0 -> READ.
- READ: each FFT_DATAO_VALID beat feeds the power pipe with index=beat counter; counter++. On beat POINTS-1 -> IDLE. Timer resets on every beat; if timer reaches TIMEOUT -> ERR=1, IDLE (partial frame discarded; M_LAST not issued).
- FFT_DATAO_VALID outside READ: ignored, sets ERR.
- Power pipe: stage 1 registers re*re and im*im (each signed WIDTH×WIDTH, result ≤ 2^(2W-2), held in 2W-1 bits unsigned); stage 2 registers sum, zero-extended to 2W bits — no overflow possible (max 2^(2W-1)). Index and last flag travel alongside.
- Pipeline is not flushed by the timeout; in-flight beats complete.

## Timing
- Reset values: S_READY=0, FFT_DATAI_VALID=0, FFT_DATAI_RE/IM=0, FFT_READ_OUTP=0, M_VALID=0, M_LAST=0, M_POWER=0, M_INDEX=0, ERR=0, state IDLE, all counters/timer 0.
- IDLE->LOAD: S_READY high the cycle after FFT_BUF_READY sampled high.
- Sample latency: transfer in cycle n -> FFT_DATAI_VALID/data in cycle n+1.
- FFT_READ_OUTP: asserted the cycle after FFT_OUTP_READY sampled high in WAIT_OUT.
- Result latency: FFT_DATAO_VALID in cycle n -> M_VALID in cycle n+2; back-to-back beats produce back-to-back M_VALID.
- READ->IDLE on last beat; a new LOAD may start the following cycle if FFT_BUF_READY=1, while the last two power outputs still drain.
- RST mid-frame: all state cleared next edge, pipe emptied; controller returns to IDLE and waits for FFT_BUF_READY (core reset handled separately).

## Test plan
- POINTS=16, BUF_READY high, 16 continuous samples re=k, im=0 -> 16 FFT_DATAI_VALID pulses, data k, S_READY low after 16th; no 17th accept.
- S_VALID toggling every other cycle -> exactly 16 transfers, FFT_DATAI_VALID only on transfer+1 cycles.
- OUTP_READY high, core returns 16 beats re=3, im=-4 -> one READ_OUTP pulse, 16 M_VALID with M_POWER=25, M_INDEX 0..15, M_LAST only on 15, each 2 cycles after beat.
- Extreme: re=im=-2^(WIDTH-1) -> M_POWER=2^(2*WIDTH-1), no wrap.
- TIMEOUT=32, core stops after 5 beats -> ERR=1 exactly 32 idle cycles after beat 5, state IDLE, no M_LAST; ERR survives until RST.
- RST asserted in LOAD after 7 samples -> next cycle S_READY=0, all outputs at reset values; fresh frame then loads 16 samples normally.
